instr_mem_bridge: RTL and testbench
===================================

# instr_mem_bridge

Bridges the RISC-V core instruction-fetch port (req/gnt/rvalid handshake) to a synchronous single-port instruction memory (boot ROM / instruction SRAM) with a configurable number of wait states. The block sits directly upstream of the core's instruction interface (`instr_req_o`/`instr_gnt_i`/`instr_rvalid_i`/`instr_addr_o`/`instr_rdata_i`) in `mcu_top_riscv` and drives the memory macro.

- Accepts at most one outstanding fetch.
- With zero wait states, sustains one fetch per cycle.
- Flags out-of-range fetches.

## Interface

Parameters:
- `BASE_ADDR`, default `32'h0000_0000`: byte base address of the instruction memory.
- `MEM_ADDR_WIDTH`, default 12: word-address width of the memory; the window is 4·2^MEM_ADDR_WIDTH bytes.
- `WAIT_STATES`, default 0: extra memory read cycles, legal range 0..7.

Ports:
- `clock`  in  1  the single clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_enable_i`  in  1  when low, no new request is granted.
- `instr_req_i`  in  1  fetch request from the core.
- `instr_addr_i`  in  32  fetch byte address; bits [1:0] are ignored.
- `instr_gnt_o`  out  1  request accepted this cycle.
- `instr_rvalid_o`  out  1  response valid.
- `instr_rdata_o`  out  32  fetched instruction word.
- `instr_err_o`  out  1  out-of-range fetch, qualified by `instr_rvalid_o`.
- `mem_en_o`  out  1  memory read strobe, one cycle per access.
- `mem_addr_o`  out  MEM_ADDR_WIDTH  memory word address.
- `mem_rdata_i`  in  32  memory read data, valid 1+WAIT_STATES cycles after `mem_en_o`.

## Operation

- States: IDLE, WAIT, RESP. A 3-bit wait counter `wcnt` tracks WAIT.
- Grant rule:
  - `instr_gnt_o` = `instr_req_i` & `fetch_enable_i` & (state==IDLE | state==RESP).
  - Grant is combinational from the inputs.
- On grant:
  - Compute `in_range` = (`instr_addr_i` >= BASE_ADDR) & (`instr_addr_i` < BASE_ADDR + 4·2^MEM_ADDR_WIDTH).
  - Register `err_q` = !in_range.
  - If in range, assert `mem_en_o` in the same cycle with `mem_addr_o` = (`instr_addr_i` − BASE_ADDR)[MEM_ADDR_WIDTH+1:2].
  - If out of range, leave `mem_en_o` low.
  - Next state: RESP if WAIT_STATES==0; otherwise WAIT with `wcnt` = WAIT_STATES−1.
- WAIT:
  - `wcnt` decrements each cycle.
  - Goes to RESP when `wcnt`==0.
  - `mem_addr_o` holds its value.
  - No grant is issued.
- RESP:
  - `instr_rvalid_o`=1 for exactly one cycle.
  - `instr_rdata_o` = `err_q` ? 0 : `mem_rdata_i`.
  - `instr_err_o` = `err_q`.
  - A new grant in the same cycle restarts the sequence; otherwise the state returns to IDLE.
- `instr_rdata_o` and `instr_err_o` drive 0 whenever `instr_rvalid_o`=0.
- `mem_addr_o` holds its last value when `mem_en_o`=0.
- Deasserting `fetch_enable_i` blocks only new grants. A fetch already in flight always completes with its rvalid.
- Address wrap: BASE_ADDR + window is computed in 33 bits, so a window touching 2^32 does not wrap.

## Timing

- Reset (`reset_n`=0, asynchronous): state=IDLE, `wcnt`=0, `err_q`=0, `mem_addr_o`=0.
  - All outputs are 0 immediately, including `instr_gnt_o` and `mem_en_o`, which are gated by the reset state.
- Reset mid-fetch: the outstanding fetch is dropped and no rvalid is issued after release.
- Latency: grant in cycle N gives rvalid in cycle N+1+WAIT_STATES.
- Throughput:
  - 1 fetch/cycle at WAIT_STATES=0 (back-to-back grants in RESP).
  - 1 fetch per 1+WAIT_STATES cycles otherwise.
- The core must hold `instr_addr_i` stable only in the grant cycle; the address is captured on grant.
- Simultaneous events: in RESP, a response and a new grant in the same cycle is legal and required. The new `err_q` and `mem_addr_o` take effect without corrupting the current `instr_rdata_o`, because memory data for the new access is not sampled until its own RESP.

## Test plan

- Reset, WAIT_STATES=0, BASE_ADDR=0:
  - Stimulus: req at addr `0x10`.
  - Response: gnt the same cycle, `mem_en_o`=1, `mem_addr_o`=4; next cycle rvalid=1, rdata=`mem_rdata_i` (`0x00000013`), err=0.
- Back-to-back, WAIT_STATES=0:
  - Stimulus: req held high for addresses 0, 4, 8, 12.
  - Response: four consecutive grants; rvalids in cycles 1..4 with words 0..3 in order.
- WAIT_STATES=3:
  - Stimulus: req at `0x20`, req kept high.
  - Response: rvalid exactly 4 cycles after grant; no second grant until the RESP cycle; `mem_addr_o`=8 held throughout.
- Out-of-range, MEM_ADDR_WIDTH=12:
  - Stimulus: req at `0x4000`.
  - Response: granted, `mem_en_o`=0; rvalid next cycle with err=1, rdata=0. The following in-range fetch returns err=0.
- `fetch_enable_i` low with req high:
  - Response: no gnt for 10 cycles. Raising `fetch_enable_i` grants in the same cycle.
- Reset mid-fetch, WAIT_STATES=5:
  - Stimulus: assert `reset_n`=0 two cycles after grant.
  - Response: all outputs 0 at once; after release, no spurious rvalid, and a fresh request completes normally.

Source files
------------

// File: rtl/instr_mem_bridge.sv
// Instruction-fetch bridge: core req/gnt/rvalid port to a synchronous
// single-port instruction memory with a fixed number of wait states.
module instr_mem_bridge #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MEM_ADDR_WIDTH = 12,
   parameter int          WAIT_STATES    = 0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      fetch_enable_i,
   input  logic                      instr_req_i,
   input  logic [31:0]               instr_addr_i,
   output logic                      instr_gnt_o,
   output logic                      instr_rvalid_o,
   output logic [31:0]               instr_rdata_o,
   output logic                      instr_err_o,
   output logic                      mem_en_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [31:0]               mem_rdata_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // 33-bit window end so a window ending at 2^32 does not wrap
   localparam logic [32:0] WIN_END =
      {1'b0, BASE_ADDR} + (33'd4 << MEM_ADDR_WIDTH);
   localparam logic [2:0] WS_INIT =
      3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   logic [1:0]                state_q, state_d;
   logic [2:0]                wcnt_q, wcnt_d;
   logic                      err_q;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [MEM_ADDR_WIDTH-1:0] word_off;
   logic                      in_range;
   logic                      can_gnt;

   assign can_gnt = (state_q == S_IDLE) | (state_q == S_RESP);

   // Gated by reset_n so grant is low the moment reset asserts
   assign instr_gnt_o = reset_n & instr_req_i
                      & fetch_enable_i & can_gnt;

   assign in_range = (instr_addr_i >= BASE_ADDR)
                   & ({1'b0, instr_addr_i} < WIN_END);

   assign word_off =
      MEM_ADDR_WIDTH'((instr_addr_i - BASE_ADDR) >> 2);

   assign mem_en_o   = instr_gnt_o & in_range;
   assign mem_addr_o = mem_en_o ? word_off : addr_q;

   assign instr_rvalid_o = (state_q == S_RESP);
   assign instr_err_o    = instr_rvalid_o & err_q;
   assign instr_rdata_o  = (instr_rvalid_o & ~err_q)
                         ? mem_rdata_i : 32'h0;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_WAIT: begin
            if (wcnt_q == 3'd0) state_d = S_RESP;
            else                wcnt_d  = wcnt_q - 3'd1;
         end
         S_RESP: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            wcnt_d  = 3'd0;
         end
      endcase
      if (instr_gnt_o) begin
         if (WAIT_STATES == 0) begin
            state_d = S_RESP;
         end else begin
            state_d = S_WAIT;
            wcnt_d  = WS_INIT;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         wcnt_q  <= 3'd0;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (instr_gnt_o) err_q  <= ~in_range;
         if (mem_en_o)    addr_q <= word_off;
      end
   end

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Bench for instr_mem_bridge: three instances (0/3/5 wait states, two
// base addresses) driven in lockstep and checked against a cycle model.
module tb_instr_mem_bridge;

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 5;
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 2) ? 32'hFFFF_C000 : 32'h0000_0000;
   endfunction

   function automatic logic [31:0] word(input logic [11:0] a);
      return ((32'(a) ^ 32'd4) * 32'h9E37_79B1) ^ 32'h13;
   endfunction

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        req;
   logic [31:0] addr;

   logic [2:0]        gnt, rv, err, men;
   logic [2:0][31:0]  rdata, mrd;
   logic [2:0][11:0]  maddr;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   int          free_at [3];
   bit          pend_m  [3];
   int          due     [3];
   logic [31:0] edata   [3];
   bit          eerr    [3];
   logic [11:0] last    [3];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar k = 0; k < 3; k++) begin : g_dut
      logic        pend = 1'b0;
      logic [2:0]  cnt  = 3'd0;
      logic [11:0] pa   = 12'd0;

      instr_mem_bridge #(
         .BASE_ADDR      (base_of(k)),
         .MEM_ADDR_WIDTH (12),
         .WAIT_STATES    (ws_of(k))
      ) u_dut (
         .clock          (clk),
         .reset_n        (rst_n),
         .fetch_enable_i (fetch_en),
         .instr_req_i    (req),
         .instr_addr_i   (addr),
         .instr_gnt_o    (gnt[k]),
         .instr_rvalid_o (rv[k]),
         .instr_rdata_o  (rdata[k]),
         .instr_err_o    (err[k]),
         .mem_en_o       (men[k]),
         .mem_addr_o     (maddr[k]),
         .mem_rdata_i    (mrd[k])
      );

      // memory: data is only valid once 1+WS cycles have elapsed
      always @(posedge clk) begin
         if (men[k]) begin
            pend <= 1'b1;
            cnt  <= 3'(ws_of(k));
            pa   <= maddr[k];
         end else if (pend && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
      end
      assign mrd[k] = (pend && cnt == 3'd0) ? word(pa) : 32'hBAD0_BAD0;
   end

   task automatic chk(input string tag,
                      input logic [47:0] obs,
                      input logic [47:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         logic [32:0] a33, lo, hi;
         logic [11:0] idx;
         logic [47:0] obs, expv;
         bit inr, eg, erv, een;
         if (!rst_n) begin
            pend_m[k]  = 1'b0;
            free_at[k] = 0;
            last[k]    = 12'd0;
         end
         a33 = {1'b0, addr};
         lo  = {1'b0, base_of(k)};
         hi  = lo + 33'h4000;
         inr = (a33 >= lo) && (a33 < hi);
         idx = 12'((addr - base_of(k)) >> 2);
         eg  = rst_n && req && fetch_en && (cyc >= free_at[k]);
         erv = rst_n && pend_m[k] && (due[k] == cyc);
         een = eg && inr;
         expv = {eg, erv, erv && eerr[k],
                 erv ? edata[k] : 32'h0,
                 een, een ? idx : last[k]};
         obs  = {gnt[k], rv[k], err[k], rdata[k], men[k], maddr[k]};
         chk($sformatf("dut%0d_cyc%0d", k, cyc), obs, expv);
         if (rst_n) begin
            if (erv) pend_m[k] = 1'b0;
            if (eg) begin
               pend_m[k]  = 1'b1;
               due[k]     = cyc + 1 + ws_of(k);
               free_at[k] = due[k];
               edata[k]   = inr ? word(idx) : 32'h0;
               eerr[k]    = !inr;
            end
            if (een) last[k] = idx;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n    = 1'b0;
      fetch_en = 1'b1;
      req      = 1'b0;
      addr     = 32'h0;
      for (int k = 0; k < 3; k++) begin
         free_at[k] = 0;
         pend_m[k]  = 1'b0;
         due[k]     = 0;
         edata[k]   = 32'h0;
         eerr[k]    = 1'b0;
         last[k]    = 12'd0;
      end
      req = 1'b1;
      steps(3);
      req   = 1'b0;
      rst_n = 1'b1;
      steps(2);

      // single fetch at 0x10
      req  = 1'b1;
      addr = 32'h10;
      #1;
      chk("first_gnt", 48'({gnt[0], men[0], maddr[0]}), 48'h3004);
      step();
      req = 1'b0;
      chk("first_rdata", 48'(rdata[0]), 48'h13);
      chk("first_valid", 48'({rv[0], err[0]}), 48'h2);
      steps(7);

      // back-to-back words 0..3
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr = 32'(i * 4);
         step();
      end
      req = 1'b0;
      chk("b2b_last", 48'(rdata[0]), 48'(word(12'd3)));
      steps(7);

      // held request at 0x20
      req  = 1'b1;
      addr = 32'h20;
      steps(9);
      req = 1'b0;
      steps(7);

      // out-of-range then in-range
      req  = 1'b1;
      addr = 32'h4000;
      #1;
      chk("oor_en", 48'({gnt[0], men[0]}), 48'h2);
      step();
      chk("oor_resp", 48'({rv[0], err[0], rdata[0]}), 48'h3_0000_0000);
      addr = 32'h30;
      step();
      req = 1'b0;
      chk("oor_next", 48'({rv[0], err[0]}), 48'h2);
      steps(7);

      // fetch enable low
      fetch_en = 1'b0;
      req      = 1'b1;
      addr     = 32'h44;
      steps(10);
      fetch_en = 1'b1;
      #1;
      chk("en_gnt", 48'(gnt[0]), 48'h1);
      step();
      req = 1'b0;
      steps(7);

      // reset two cycles into a WS=5 fetch
      req  = 1'b1;
      addr = 32'hFFFF_C010;
      step();
      req = 1'b0;
      steps(2);
      rst_n = 1'b0;
      req   = 1'b1;
      #1;
      chk("rst_now", 48'({gnt, rv, men, maddr[2]}), 48'h0);
      steps(2);
      req   = 1'b0;
      rst_n = 1'b1;
      steps(8);
      req  = 1'b1;
      addr = 32'hFFFF_C020;
      step();
      req = 1'b0;
      steps(7);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n    = ($urandom_range(0, 149) != 0);
         req      = ($urandom_range(0, 3) != 0);
         fetch_en = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 5))
            0, 1:    addr = 32'($urandom_range(0, 32'h3FFF));
            2:       addr = 32'h3FF0 + 32'($urandom_range(0, 31));
            3:       addr = 32'hFFFF_C000
                          + 32'($urandom_range(0, 32'h3FFF));
            4:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: addr = $urandom;
         endcase
         step();
      end
      rst_n = 1'b1;
      req   = 1'b0;
      steps(8);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
